// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute-to-memory pipeline register with a 2-entry skid buffer, branch redirect and stall counter
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_branch_taken,
  input  logic [DATA_W-1:0] ex_branch_target,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_dest_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_dest_reg,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_reg_write,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);
  localparam int E_W = 2*DATA_W + REG_W + 3;
  logic [E_W-1:0] main_q, skid_q, in_e;
  logic main_valid, skid_valid, accept, pop;
  assign in_e = {ex_alu_result, ex_store_data, ex_dest_reg, ex_mem_read, ex_mem_write, ex_reg_write};
  assign ex_ready = !skid_valid;
  assign accept = ex_valid && ex_ready;
  assign pop = main_valid && mem_ready;
  assign mem_valid = main_valid;
  assign occupancy = {skid_valid, main_valid && !skid_valid};
  assign {mem_alu_result, mem_store_data, mem_dest_reg, mem_mem_read, mem_mem_write, mem_reg_write} = main_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      stall_count <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= accept && ex_branch_taken;
      if (accept && ex_branch_taken) redirect_pc <= ex_branch_target;
      // skid only ever fills when main is held, so it refills main on pop
      main_valid <= skid_valid || accept || (main_valid && !pop);
      skid_valid <= skid_valid ? !pop : (accept && main_valid && !pop);
      if (skid_valid && pop) main_q <= skid_q;
      else if (accept && (!main_valid || pop)) main_q <= in_e;
      if (accept && main_valid && !pop) skid_q <= in_e;
      if (ex_valid && !ex_ready && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed checks of handshake, ordering, redirect, flush, reset and stall saturation
module tb_ex_mem_stage;
  logic clk = 1'b0, reset, flush, ex_valid, ex_ready, ex_branch_taken;
  logic [31:0] ex_alu_result, ex_branch_target, ex_store_data;
  logic [4:0] ex_dest_reg;
  logic ex_mem_read, ex_mem_write, ex_reg_write, mem_valid, mem_ready;
  logic [31:0] mem_alu_result, mem_store_data, redirect_pc;
  logic [4:0] mem_dest_reg;
  logic mem_mem_read, mem_mem_write, mem_reg_write, redirect_valid;
  logic [1:0] occupancy;
  logic [3:0] stall_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ex_mem_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_dest_reg(mem_dest_reg),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .occupancy(occupancy), .stall_count(stall_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1; flush = 0; ex_valid = 0; ex_branch_taken = 0; ex_alu_result = 0; ex_branch_target = 0;
    ex_store_data = 0; ex_dest_reg = 0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; mem_ready = 0;
    step(); step();
    reset = 0;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", ex_ready, 1);
    chk("rst_redir", redirect_valid, 0);
    chk("rst_stall", stall_count, 0);
    ex_valid = 1; ex_alu_result = 32'h10; ex_reg_write = 1; ex_dest_reg = 5; ex_store_data = 32'hab;
    ex_mem_write = 1; mem_ready = 1;
    step();
    ex_valid = 0; ex_mem_write = 0;
    chk("t1_valid", mem_valid, 1);
    chk("t1_alu", mem_alu_result, 32'h10);
    chk("t1_dest", mem_dest_reg, 5);
    chk("t1_rw", mem_reg_write, 1);
    chk("t1_store", mem_store_data, 32'hab);
    chk("t1_mw", mem_mem_write, 1);
    step();
    chk("t1_occ0", occupancy, 0);
    chk("t1_drain", mem_valid, 0);
    mem_ready = 0; ex_valid = 1; ex_alu_result = 1;
    step();
    chk("t2_occ1", occupancy, 1);
    ex_alu_result = 2;
    step();
    ex_alu_result = 3;
    chk("t2_occ2", occupancy, 2);
    chk("t2_notready", ex_ready, 0);
    step();
    chk("t2_stall1", stall_count, 1);
    step();
    chk("t2_stall2", stall_count, 2);
    chk("t2_hold", mem_alu_result, 1);
    mem_ready = 1;
    step();
    chk("t2_pop2", mem_alu_result, 2);
    chk("t2_stall3", stall_count, 3);
    step();
    ex_valid = 0;
    chk("t2_pop3", mem_alu_result, 3);
    chk("t2_occ_last", occupancy, 1);
    step();
    chk("t2_empty", occupancy, 0);
    ex_valid = 1; ex_branch_taken = 1; ex_branch_target = 32'h40; ex_alu_result = 32'h44;
    step();
    ex_valid = 0; ex_branch_taken = 0;
    chk("t3_redir", redirect_valid, 1);
    chk("t3_pc", redirect_pc, 32'h40);
    chk("t3_entry", mem_alu_result, 32'h44);
    step();
    chk("t3_pulse_end", redirect_valid, 0);
    mem_ready = 0; ex_valid = 1; ex_alu_result = 5;
    step();
    ex_alu_result = 6;
    step();
    chk("t4_full", occupancy, 2);
    ex_branch_taken = 1; ex_branch_target = 32'h80; flush = 1;
    step();
    flush = 0; ex_valid = 0; ex_branch_taken = 0;
    chk("t4_occ", occupancy, 0);
    chk("t4_valid", mem_valid, 0);
    chk("t4_ready", ex_ready, 1);
    chk("t4_redir", redirect_valid, 0);
    chk("t4_stall", stall_count, 3);
    ex_valid = 1; ex_alu_result = 7;
    step();
    ex_alu_result = 8;
    step();
    ex_valid = 0;
    chk("t5_full", occupancy, 2);
    reset = 1;
    step();
    reset = 0;
    chk("t5_valid", mem_valid, 0);
    chk("t5_occ", occupancy, 0);
    chk("t5_ready", ex_ready, 1);
    chk("t5_pc", redirect_pc, 0);
    chk("t5_alu", mem_alu_result, 0);
    chk("t5_dest", mem_dest_reg, 0);
    chk("t5_stall", stall_count, 0);
    ex_valid = 1; ex_alu_result = 32'h99; mem_ready = 1;
    step();
    chk("t5_new", mem_alu_result, 32'h99);
    chk("t5_new_valid", mem_valid, 1);
    mem_ready = 0; ex_alu_result = 1;
    for (int i = 0; i < 20; i++) step();
    chk("t6_sat", stall_count, 15);
    chk("t6_full", occupancy, 2);
    for (int i = 0; i < 3; i++) step();
    chk("t6_held", stall_count, 15);
    chk("t6_stable", mem_alu_result, 32'h99);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
